// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and angle clamp for the SG90 servo ramp controller.
package servo_pkg;

  localparam int unsigned CLK_PER_UNIT  = 5000;
  localparam int unsigned FRAME_UNITS   = 200;
  localparam logic [7:0]  ANG_MIN       = 8'd5;
  localparam logic [7:0]  ANG_MAX       = 8'd25;
  localparam logic [7:0]  ANG_RESET     = 8'd15;
  localparam int unsigned STEP          = 1;
  localparam int unsigned HOLD_FRAMES   = 2;
  localparam int unsigned SETTLE_FRAMES = 10;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } servo_state_e;

  function automatic logic [7:0] clamp_angle(input logic [7:0] a,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
    if (a < lo)      return lo;
    else if (a > hi) return hi;
    else             return a;
  endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Target-angle command handshake between the host logic and the servo ramp controller.
interface servo_ramp_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_angle;

  modport master (output cmd_valid, output cmd_angle, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_angle, output cmd_ready);

endinterface

// File: rtl/servo_frame_timer.sv
// PWM frame timer: unit counter nested inside a frame counter; frame_tick marks frame start.
module servo_frame_timer #(
  parameter int unsigned CLK_PER_UNIT = servo_pkg::CLK_PER_UNIT,
  parameter int unsigned FRAME_UNITS  = servo_pkg::FRAME_UNITS
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int unsigned UW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam int unsigned FW = (FRAME_UNITS > 1)  ? $clog2(FRAME_UNITS)  : 1;

  logic [UW-1:0] unit_q, unit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          tick_q, tick_d;

  // Tick is registered so it is high exactly while both counters sit at zero.
  always_comb begin
    unit_d  = unit_q + 1'b1;
    frame_d = frame_q;
    tick_d  = 1'b0;
    if (unit_q == UW'(CLK_PER_UNIT - 1)) begin
      unit_d = '0;
      if (frame_q == FW'(FRAME_UNITS - 1)) begin
        frame_d = '0;
        tick_d  = 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_q  <= '0;
      frame_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      unit_q  <= unit_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/servo_ramp_ctrl.sv
// SG90 servo angle sequencer: accepts a clamped target and ramps angle_out at frame boundaries.
module servo_ramp_ctrl #(
  parameter int unsigned CLK_PER_UNIT  = servo_pkg::CLK_PER_UNIT,
  parameter int unsigned FRAME_UNITS   = servo_pkg::FRAME_UNITS,
  parameter logic [7:0]  ANG_MIN       = servo_pkg::ANG_MIN,
  parameter logic [7:0]  ANG_MAX       = servo_pkg::ANG_MAX,
  parameter logic [7:0]  ANG_RESET     = servo_pkg::ANG_RESET,
  parameter int unsigned STEP          = servo_pkg::STEP,
  parameter int unsigned HOLD_FRAMES   = servo_pkg::HOLD_FRAMES,
  parameter int unsigned SETTLE_FRAMES = servo_pkg::SETTLE_FRAMES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  servo_ramp_ctrl_if.slave        cmd,
  input  logic                    abort,
  output logic [7:0]              angle_out,
  output logic                    frame_tick,
  output logic                    busy,
  output logic                    done,
  output logic                    clamped,
  output logic                    aborted
);

  import servo_pkg::servo_state_e;
  import servo_pkg::IDLE;
  import servo_pkg::RAMP;
  import servo_pkg::SETTLE;
  import servo_pkg::clamp_angle;

  localparam int unsigned HW    = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned SW    = $clog2(SETTLE_FRAMES + 1);
  localparam logic [7:0]  STEP8 = 8'(STEP);

  servo_state_e  state_q, state_d;
  logic [7:0]    angle_q, angle_d;
  logic [7:0]    target_q, target_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          done_q, done_d;
  logic          clamped_q, clamped_d;
  logic          aborted_q, aborted_d;

  logic          tick;
  logic          ready;
  logic [7:0]    cmd_clamped;
  logic [7:0]    next_angle;

  servo_frame_timer #(
    .CLK_PER_UNIT (CLK_PER_UNIT),
    .FRAME_UNITS  (FRAME_UNITS)
  ) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (tick)
  );

  assign ready       = (state_q == IDLE) && !abort;
  assign cmd_clamped = clamp_angle(cmd.cmd_angle, ANG_MIN, ANG_MAX);

  // Compare before add/subtract so the final step lands exactly on target.
  always_comb begin
    next_angle = angle_q;
    if (target_q > angle_q) begin
      next_angle = ((target_q - angle_q) < STEP8) ? target_q : angle_q + STEP8;
    end else if (target_q < angle_q) begin
      next_angle = ((angle_q - target_q) < STEP8) ? target_q : angle_q - STEP8;
    end
  end

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    target_d  = target_q;
    hold_d    = hold_q;
    settle_d  = settle_q;
    done_d    = 1'b0;
    clamped_d = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && ready) begin
          target_d  = cmd_clamped;
          clamped_d = (cmd_clamped != cmd.cmd_angle);
          hold_d    = '0;
          settle_d  = '0;
          state_d   = (cmd_clamped == angle_q) ? SETTLE : RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (tick) begin
          if (hold_q == HW'(HOLD_FRAMES - 1)) begin
            hold_d  = '0;
            angle_d = next_angle;
            if (next_angle == target_q) begin
              settle_d = '0;
              state_d  = SETTLE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (tick) begin
          if (settle_q == SW'(SETTLE_FRAMES - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      angle_q   <= ANG_RESET;
      target_q  <= ANG_RESET;
      hold_q    <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      target_q  <= target_d;
      hold_q    <= hold_d;
      settle_q  <= settle_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd.cmd_ready = ready;
  assign angle_out     = angle_q;
  assign frame_tick    = tick;
  assign busy          = (state_q == RAMP) || (state_q == SETTLE);
  assign done          = done_q;
  assign clamped       = clamped_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Randomized self-checking bench for servo_ramp_ctrl: STEP=1 and STEP=4 instances vs. a frame-count model.
module tb_servo_ramp_ctrl;

  localparam int CPU    = 4;
  localparam int FU     = 5;
  localparam int FRAME  = CPU * FU;
  localparam int HOLD   = 2;
  localparam int SETTLE = 10;

  logic       clk;
  logic       rst_n;
  logic       abort_i [2];
  logic [7:0] ang_o   [2];
  logic       tick_o  [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       clamp_o [2];
  logic       abt_o   [2];
  logic       rdy     [2];

  int n_tests;
  int n_fail;
  int cur [2];

  servo_ramp_ctrl_if if0 ();
  servo_ramp_ctrl_if if1 ();

  assign rdy[0] = if0.cmd_ready;
  assign rdy[1] = if1.cmd_ready;

  servo_ramp_ctrl #(.CLK_PER_UNIT(CPU), .FRAME_UNITS(FU), .STEP(1),
                    .HOLD_FRAMES(HOLD), .SETTLE_FRAMES(SETTLE)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(if0.slave), .abort(abort_i[0]),
    .angle_out(ang_o[0]), .frame_tick(tick_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .clamped(clamp_o[0]), .aborted(abt_o[0]));

  servo_ramp_ctrl #(.CLK_PER_UNIT(CPU), .FRAME_UNITS(FU), .STEP(4),
                    .HOLD_FRAMES(HOLD), .SETTLE_FRAMES(SETTLE)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(if1.slave), .abort(abort_i[1]),
    .angle_out(ang_o[1]), .frame_tick(tick_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .clamped(clamp_o[1]), .aborted(abt_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic ab);
    if (sel == 0) begin if0.cmd_valid = v; if0.cmd_angle = a; end
    else          begin if1.cmd_valid = v; if1.cmd_angle = a; end
    abort_i[sel] = ab;
  endtask

  function automatic int clamp_ref(input int a);
    return (a < 5) ? 5 : (a > 25) ? 25 : a;
  endfunction

  // Position after k frame ticks: one STEP per HOLD ticks, travel capped at |delta|.
  function automatic int model_angle(input int st, input int tgt, input int step, input int k);
    int mv, d;
    mv = (k / HOLD) * step;
    d  = tgt - st;
    if (d >= 0) return st + ((mv < d) ? mv : d);
    else        return st - ((mv < -d) ? mv : -d);
  endfunction

  task automatic run_cmd(input int sel, input int ang, input int abort_at, input int rst_at);
    int tgt, st, step, d, nst, total, k, cyc, limit, exp_ang;
    bit fin;
    tgt   = clamp_ref(ang);
    st    = cur[sel];
    step  = (sel == 0) ? 1 : 4;
    d     = (tgt > st) ? tgt - st : st - tgt;
    nst   = (d + step - 1) / step;
    total = nst * HOLD + SETTLE;
    limit = (total + 2) * FRAME + 50;

    @(negedge clk);
    chk("ready_idle", 32'(rdy[sel]), 1);
    drive(sel, 1'b1, 8'(ang), 1'b0);
    @(negedge clk);
    drive(sel, 1'b0, 8'(ang), 1'b0);
    chk("clamped", 32'(clamp_o[sel]), 32'(tgt != ang));

    k = 0; cyc = 0; fin = 0;
    while (!fin) begin
      exp_ang = model_angle(st, tgt, step, k);
      if (k == total) begin
        chk("done", 32'(done_o[sel]), 1);
        chk("busy_end", 32'(busy_o[sel]), 0);
        chk("ready_end", 32'(rdy[sel]), 1);
        chk("angle_end", 32'(ang_o[sel]), 32'(exp_ang));
        cur[sel] = exp_ang;
        @(negedge clk);
        chk("done_pulse", 32'(done_o[sel]), 0);
        fin = 1;
      end else begin
        chk("angle", 32'(ang_o[sel]), 32'(exp_ang));
        chk("busy", 32'(busy_o[sel]), 1);
        chk("no_done", 32'(done_o[sel]), 0);
        if (tick_o[sel]) begin
          k++;
          if (k == abort_at) begin
            abort_i[sel] = 1'b1;
            @(negedge clk);
            abort_i[sel] = 1'b0;
            chk("aborted", 32'(abt_o[sel]), 1);
            chk("abort_busy", 32'(busy_o[sel]), 0);
            chk("abort_angle", 32'(ang_o[sel]), 32'(exp_ang));
            chk("abort_done", 32'(done_o[sel]), 0);
            cur[sel] = exp_ang;
            fin = 1;
          end else if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_angle", 32'(ang_o[sel]), 15);
            chk("rst_busy", 32'(busy_o[sel]), 0);
            chk("rst_other", 32'(ang_o[1-sel]), 15);
            @(negedge clk);
            rst_n = 1'b1;
            cur[0] = 15;
            cur[1] = 15;
            fin = 1;
          end
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
        if (cyc > limit) begin
          chk("timeout", 32'(cyc), 32'(limit));
          fin = 1;
        end
      end
    end
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(0, 1'b0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      chk("rst_angle0", 32'(ang_o[s]), 15);
      chk("rst_ready", 32'(rdy[s]), 1);
      chk("rst_pulses", {29'd0, done_o[s], clamp_o[s], abt_o[s]}, 0);
      chk("rst_tick", 32'(tick_o[s]), 0);
    end

    rst_n = 1'b1;
    n = 0;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge clk);
      if (tick_o[0]) begin n = c; break; end
    end
    chk("first_tick", 32'(n), FRAME);
    cur[0] = 15;
    cur[1] = 15;

    run_cmd(0, 20, 0, 0);
    run_cmd(0, 200, 0, 0);
    run_cmd(0, 0, 0, 0);
    run_cmd(1, 15, 0, 0);
    run_cmd(0, 15, 0, 0);
    run_cmd(0, 20, 6, 0);

    @(negedge clk);
    drive(0, 1'b1, 8'd22, 1'b1);
    #1;
    chk("idle_abort_ready", 32'(rdy[0]), 0);
    @(negedge clk);
    drive(0, 1'b0, 8'd22, 1'b0);
    chk("idle_abort_busy", 32'(busy_o[0]), 0);
    chk("idle_abort_pulse", 32'(abt_o[0]), 0);
    @(negedge clk);
    chk("idle_abort_angle", 32'(ang_o[0]), 32'(cur[0]));

    run_cmd(1, 25, 0, 0);
    run_cmd(1, 5, 0, 3);

    for (int i = 0; i < 8; i++) begin
      int sel, ang, ab, tgt, d, step, total;
      sel  = int'($urandom_range(0, 1));
      ang  = int'($urandom_range(0, 40));
      step = (sel == 0) ? 1 : 4;
      tgt  = clamp_ref(ang);
      d    = (tgt > cur[sel]) ? tgt - cur[sel] : cur[sel] - tgt;
      total = ((d + step - 1) / step) * HOLD + SETTLE;
      ab = 0;
      if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(1, total - 1));
      run_cmd(sel, ang, ab, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
